hilo_md_ctrl: RTL and testbench

Multiply/divide sequencer and HI/LO register owner for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from EX and runs a registered multiplier and a 32-step restoring divider. It raises the EX stall request for the duration of multi-cycle ops and commits results to the architectural HI/LO registers, which EX reads for MFHI/MFLO.

---
 rtl/hilo_md_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hilo_md_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl.sv
// HI/LO register owner and multiply/divide sequencer for the EX stage.
// One-cycle registered multiplier and a 32-step restoring divider.
module hilo_md_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        ex_hold_i,
  input  logic        annul_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE,
    S_HOLD
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_e      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  count_q;
  // a_q: multiplicand, or dividend magnitude that shifts into the quotient.
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic        sgn_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  // Operation decode in IDLE.
  logic        in_idle;
  logic        md_op;
  logic        mul_op;
  logic        signed_op;
  logic        accept;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;

  assign in_idle   = (state_q == S_IDLE);
  assign md_op     = ~op_i[2];
  assign mul_op    = (op_i[2:1] == 2'b00);
  assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign accept    = in_idle & op_valid_i & md_op & ~annul_i;
  assign mt_hi     = in_idle & op_valid_i & ~annul_i & (op_i == OP_MTHI);
  assign mt_lo     = in_idle & op_valid_i & ~annul_i & (op_i == OP_MTLO);
  assign dvd_mag   = (signed_op && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
  assign dvs_mag   = (signed_op && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

  // Multiplier: the low 64 bits of the product of the sign- or zero-extended
  // operands equal the signed or unsigned 64-bit product.
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product_d;

  assign ext_a     = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b     = {{32{sgn_q & b_q[31]}}, b_q};
  assign product_d = ext_a * ext_b;

  // Restoring divide step: the 33-bit trial subtraction keeps the borrow,
  // which is the inverted quotient bit.
  logic [32:0] trial_d;
  logic        q_bit_d;
  logic [31:0] rem_d;
  logic [31:0] quo_final_d;
  logic [31:0] quo_signed_d;
  logic [31:0] rem_signed_d;

  assign trial_d      = {rem_q, a_q[31]} - {1'b0, b_q};
  assign q_bit_d      = ~trial_d[32];
  assign rem_d        = q_bit_d ? trial_d[31:0] : {rem_q[30:0], a_q[31]};
  assign quo_final_d  = {a_q[30:0], q_bit_d};
  assign quo_signed_d = neg_quo_q ? (~quo_final_d + 32'd1) : quo_final_d;
  assign rem_signed_d = neg_rem_q ? (~rem_d + 32'd1) : rem_d;

  // NOTE: all state is updated with non-blocking assignments in one clocked
  // block so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      count_q   <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (annul_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sgn_q  <= signed_op;
            busy_q <= 1'b1;
            if (mul_op) begin
              a_q     <= src_a_i;
              b_q     <= src_b_i;
              state_q <= S_MUL;
            end else if (src_b_i == 32'd0) begin
              hi_q    <= src_a_i;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              a_q       <= dvd_mag;
              b_q       <= dvs_mag;
              rem_q     <= 32'd0;
              count_q   <= 5'd0;
              neg_quo_q <= signed_op & (src_a_i[31] ^ src_b_i[31]);
              neg_rem_q <= signed_op & src_a_i[31];
              state_q   <= S_DIV;
            end
          end else if (mt_hi) begin
            hi_q <= src_a_i;
          end else if (mt_lo) begin
            lo_q <= src_a_i;
          end
        end

        S_MUL: begin
          hi_q    <= product_d[63:32];
          lo_q    <= product_d[31:0];
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end

        S_DIV: begin
          a_q     <= quo_final_d;
          rem_q   <= rem_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            hi_q    <= rem_signed_d;
            lo_q    <= quo_signed_d;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          if (ex_hold_i) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!ex_hold_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The stall must be seen in the accept cycle itself, so it is decoded
  // from the current state and inputs rather than registered.
  assign stallreq_o = accept | (state_q == S_MUL) | (state_q == S_DIV);
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed vector table, hand-written
// corner sequences and random operations against an arithmetic model.
module tb_hilo_md_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ex_hold;
  logic        annul;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  hilo_md_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid),
    .op_i       (op),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .ex_hold_i  (ex_hold),
    .annul_i    (annul),
    .stallreq_o (stallreq),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  // Result of an operation from the arithmetic definition: {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (mop)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (mop == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic int model_stalls(input logic [2:0] mop, input logic [31:0] b);
    if (mop <= 3'd1) return 2;
    return (b == 32'd0) ? 1 : 33;
  endfunction

  // Issue an op as EX would: held while stalled, dropped once done shows.
  // Entered and left at posedge+1; samples at the falling edge.
  task automatic run_op(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic saw_done,
                        output logic [31:0] h, output logic [31:0] l);
    op_valid = 1'b1;
    op       = mop;
    src_a    = a;
    src_b    = b;
    stalls   = 0;
    #4;
    while (stallreq && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #5;
    end
    saw_done = done;
    h        = hi;
    l        = lo;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic mt_write(input logic [2:0] mop, input logic [31:0] a);
    op_valid = 1'b1;
    op       = mop;
    src_a    = a;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    int          stalls;
    logic        sdone;
    logic [31:0] rh, rl;
    logic [63:0] exp;
    logic [31:0] m_hi, m_lo;
    int          done_cnt;

    vecs[0] = '{"mult_neg3x7",  3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 2};
    vecs[1] = '{"multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 2};
    vecs[2] = '{"divu_100_7",   3'd3, 32'd100,       32'd7,        32'd2,         32'd14,        33};
    vecs[3] = '{"div_neg7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{"div_7_neg2",   3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
    vecs[5] = '{"div_5_by_0",   3'd2, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
    vecs[6] = '{"div_min_neg1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};

    op_valid = 1'b0;
    op       = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    ex_hold  = 1'b0;
    annul    = 1'b0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stallreq), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, stalls, sdone, rh, rl);
      check({vecs[i].name, "_stalls"}, 64'(stalls), 64'(vecs[i].exp_stalls));
      check({vecs[i].name, "_done"}, 64'(sdone), 64'd1);
      check({vecs[i].name, "_hi"}, 64'(rh), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"}, 64'(rl), 64'(vecs[i].exp_lo));
    end

    // Back-to-back MTHI / MTLO: no stall, each value visible the next cycle.
    op_valid = 1'b1;
    op       = 3'd4;
    src_a    = 32'hCAFE_0000;
    #4;
    check("mthi_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    op    = 3'd5;
    src_a = 32'h0000_BEEF;
    #4;
    check("mtlo_stall", 64'(stallreq), 64'd0);
    check("mthi_hi", 64'(hi), 64'hCAFE_0000);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    #4;
    check("mt_hi_kept", 64'(hi), 64'hCAFE_0000);
    check("mt_lo", 64'(lo), 64'h0000_BEEF);
    check("mt_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Annul in the tenth divide cycle leaves HI/LO untouched.
    mt_write(3'd4, 32'h11);
    mt_write(3'd5, 32'h11);
    op_valid = 1'b1;
    op       = 3'd3;
    src_a    = 32'd100;
    src_b    = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
    end
    annul    = 1'b1;
    op_valid = 1'b0;
    #4;
    check("annul_busy_before", 64'(busy), 64'd1);
    check("annul_stall_before", 64'(stallreq), 64'd1);
    @(posedge clk);
    #1;
    annul = 1'b0;
    #4;
    check("annul_stall_after", 64'(stallreq), 64'd0);
    check("annul_busy_after", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(posedge clk);
      #5;
    end
    check("annul_no_done", 64'(done_cnt), 64'd0);
    check("annul_hi", 64'(hi), 64'h11);
    check("annul_lo", 64'(lo), 64'h11);
    @(posedge clk);
    #1;

    // MULT finishing while EX is held for three cycles with op_valid held.
    done_cnt = 0;
    op       = 3'd0;
    src_a    = 32'hFFFF_FFFD;
    src_b    = 32'd7;
    for (int k = 0; k <= 6; k++) begin
      ex_hold  = (k >= 2 && k <= 4);
      op_valid = (k <= 5);
      #4;
      if (done) done_cnt++;
      if (k == 2) begin
        check("hold_done_k2", 64'(done), 64'd1);
        check("hold_stall_k2", 64'(stallreq), 64'd0);
      end
      if (k == 3 || k == 5) begin
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_stall", 64'(stallreq), 64'd0);
      end
      if (k == 6) check("hold_idle_k6", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end
    ex_hold = 1'b0;
    check("hold_done_pulses", 64'(done_cnt), 64'd1);
    check("hold_hi", 64'(hi), 64'hFFFF_FFFF);
    check("hold_lo", 64'(lo), 64'hFFFF_FFEB);

    // Annul in IDLE suppresses both MT writes and acceptance.
    op_valid = 1'b1;
    annul    = 1'b1;
    op       = 3'd4;
    src_a    = 32'hDEAD_0001;
    #4;
    check("idle_annul_mt_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    op    = 3'd2;
    src_b = 32'd3;
    #4;
    check("idle_annul_div_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    annul    = 1'b0;
    #4;
    check("idle_annul_hi", 64'(hi), 64'hFFFF_FFFF);
    check("idle_annul_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Ignored opcodes 6/7 neither stall nor write.
    op_valid = 1'b1;
    op       = 3'd6;
    src_a    = 32'h1234_5678;
    #4;
    check("op6_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    #4;
    check("op6_hi", 64'(hi), 64'hFFFF_FFFF);
    check("op6_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Random operations against the arithmetic model.
    m_hi = hi === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFEB;
    for (int r = 0; r < 60; r++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          mode;
      rop  = 3'($urandom_range(0, 5));
      ra   = $urandom;
      mode = $urandom_range(0, 3);
      rb   = (mode == 0) ? 32'd0 : (mode == 1) ? 32'($urandom_range(1, 20)) :
             (mode == 2) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5)) : $urandom;
      if (rop <= 3'd3) begin
        run_op(rop, ra, rb, stalls, sdone, rh, rl);
        exp  = model(rop, ra, rb);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check("rand_stalls", 64'(stalls), 64'(model_stalls(rop, rb)));
        check("rand_done", 64'(sdone), 64'd1);
        check("rand_hi", 64'(rh), 64'(m_hi));
        check("rand_lo", 64'(rl), 64'(m_lo));
      end else begin
        op_valid = 1'b1;
        op       = rop;
        src_a    = ra;
        #4;
        check("rand_mt_stall", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (rop == 3'd4) m_hi = ra;
        else m_lo = ra;
        #4;
        check("rand_mt_hi", 64'(hi), 64'(m_hi));
        check("rand_mt_lo", 64'(lo), 64'(m_lo));
        @(posedge clk);
        #1;
      end
    end

    // Reset in the middle of a divide discards everything.
    mt_write(3'd4, 32'h55);
    op_valid = 1'b1;
    op       = 3'd2;
    src_a    = 32'd1000;
    src_b    = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst      = 1'b1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_stall", 64'(stallreq), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
